// File: rtl/onehot_enc_pkg.sv
// Shared types and sizing helpers for the one-hot request encoder.
// Optional round-robin selection is enabled by defining ONEHOT_ENC_RR_EN.
package onehot_enc_pkg;

  typedef enum logic {IDLE, HOLD} state_e;

  localparam int N_DEFAULT = 4;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_encoder_q_prio_pick.sv
// Combinational picker: first set bit of mask at or after start, wrapping modulo N.
// Zero latency; no state, so no backpressure of its own.
module prio_pick
  import onehot_enc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  // Scan from the far end back toward start so the nearest hit is written last.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = start + W'(k);
      if (mask[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_encoder_q.sv
// Collects request lines into a pending mask and emits each as a binary index over Dv/Drdy.
// Request to Dv takes two edges; a stalled consumer holds Do frozen while requests accumulate.
// Round-robin selection when ONEHOT_ENC_RR_EN is defined, else fixed lowest-index priority.
module onehot_encoder_q
  import onehot_enc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         En,
  input  logic [N-1:0] Din,
  output logic [W-1:0] Do,
  output logic         Dv,
  input  logic         Drdy,
  output logic [N-1:0] Pend,
  output logic         Err
);

  state_e       state_q;
  logic [W-1:0] do_q;
  logic         dv_q;
  logic [N-1:0] pend_q, pend_d;
  logic         err_q, err_d;
  logic [N-1:0] set_v, clr_v;
  logic         xfer;
  logic [W-1:0] start;
  logic [W-1:0] pick_idx;
  logic         pick_any;

  assign xfer = dv_q & Drdy;

  // Set wins over clear so a re-request on the transfer edge stays pending.
  always_comb begin
    set_v = En ? Din : '0;
    clr_v = '0;
    if (xfer) clr_v[do_q] = 1'b1;
    pend_d = set_v | (pend_q & ~clr_v);
    err_d  = |(set_v & pend_q & ~clr_v);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

`ifdef ONEHOT_ENC_RR_EN
  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = do_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  prio_pick #(.N(N), .W(W)) u_pick (
    .mask  (pend_q),
    .start (start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant is taken only from the registered mask, giving the mandatory IDLE bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      do_q    <= '0;
      dv_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            do_q    <= pick_idx;
            dv_q    <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (Drdy) begin
            dv_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          dv_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Do   = do_q;
  assign Dv   = dv_q;
  assign Pend = pend_q;
  assign Err  = err_q;

endmodule

// File: tb/tb_onehot_encoder_q.sv
// Randomized and directed bench for onehot_encoder_q against a request-queue style reference model.
module tb_onehot_encoder_q;
  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         En = 1'b0;
  logic [N-1:0] Din = '0;
  logic         Drdy = 1'b0;
  logic [W-1:0] Do;
  logic         Dv;
  logic [N-1:0] Pend;
  logic         Err;

  int checks = 0;
  int failures = 0;

  // Reference model: pending set, the request currently offered (-1 = none), search pointer.
  bit [N-1:0] m_pend;
  int         m_cur;
  int         m_ptr;
  bit         m_err;
  int         served[$];

  onehot_encoder_q #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .En(En), .Din(Din), .Do(Do),
    .Dv(Dv), .Drdy(Drdy), .Pend(Pend), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input bit [N-1:0] p, input int from);
    for (int k = 0; k < N; k++)
      if (p[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_cur  = -1;
    m_ptr  = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit [N-1:0] din, input bit rdy);
    bit [N-1:0] s, c;
    bit x;
    s = en ? din : '0;
    c = '0;
    x = (m_cur >= 0) && rdy;
    if (x) begin
      c[m_cur] = 1'b1;
      served.push_back(m_cur);
    end
    m_err = |(s & m_pend & ~c);
    if (m_cur < 0) begin
      if (m_pend != 0) m_cur = pick(m_pend, m_ptr);
    end else if (x) begin
`ifdef ONEHOT_ENC_RR_EN
      m_ptr = (m_cur + 1) % N;
`endif
      m_cur = -1;
    end
    m_pend = s | (m_pend & ~c);
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".Dv"},   32'(Dv),   32'(m_cur >= 0));
    check_eq({tag, ".Pend"}, 32'(Pend), 32'(m_pend));
    check_eq({tag, ".Err"},  32'(Err),  32'(m_err));
    if (m_cur >= 0) check_eq({tag, ".Do"}, 32'(Do), 32'(m_cur));
  endtask

  // Drive one cycle of inputs, advance one edge, then compare away from the edge.
  task automatic step(input string tag, input bit en, input bit [N-1:0] din, input bit rdy);
    En = en; Din = din; Drdy = rdy;
    @(posedge clk);
    model_edge(en, din, rdy);
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.Dv", 32'(Dv), 0);
    check_eq("reset.Do", 32'(Do), 0);
    check_eq("reset.Pend", 32'(Pend), 0);
    check_eq("reset.Err", 32'(Err), 0);
    rst_n = 1'b1;
    step("idle", 0, 4'b0000, 1);

    // Single request: Pend after one edge, Dv=1 Do=2 after the next, then drained.
    step("single0", 1, 4'b0100, 1);
    check_eq("single.pend_first", 32'(Pend), 32'h4);
    step("single1", 0, 4'b0000, 1);
    check_eq("single.do", 32'(Do), 32'h2);
    step("single2", 0, 4'b0000, 1);
    check_eq("single.drained", 32'(Pend), 32'h0);
    step("single3", 0, 4'b0000, 1);

    // Multi-hot burst drained with Drdy held high.
    served.delete();
    step("burst0", 1, 4'b1011, 1);
    for (int i = 0; i < 8; i++) step("burst", 0, 4'b0000, 1);
    check_eq("burst.count", 32'(served.size()), 3);
`ifndef ONEHOT_ENC_RR_EN
    if (served.size() == 3) begin
      check_eq("burst.order0", 32'(served[0]), 0);
      check_eq("burst.order1", 32'(served[1]), 1);
      check_eq("burst.order2", 32'(served[2]), 3);
    end
`endif

    // Stall in HOLD on index 1; a higher-priority arrival must not preempt it.
    step("stall0", 1, 4'b0010, 0);
    step("stall1", 0, 4'b0000, 0);
    for (int i = 0; i < 10; i++) begin
      step("stall", (i == 3), 4'b0001, 0);
      check_eq("stall.do_frozen", 32'(Do), 1);
    end
    // Duplicate of a pending, unserved line raises Err for one cycle.
    step("dup0", 1, 4'b0010, 0);
    check_eq("dup.err", 32'(Err), 1);
    check_eq("dup.pend", 32'(Pend), 32'h3);
    step("dup1", 0, 4'b0000, 0);
    check_eq("dup.err_pulse", 32'(Err), 0);
    // Re-request on the transfer edge of index 1: stays pending, no Err.
    step("rereq", 1, 4'b0010, 1);
    check_eq("rereq.err", 32'(Err), 0);
    check_eq("rereq.pend1", 32'(Pend[1]), 1);
    for (int i = 0; i < 6; i++) step("drain", 0, 4'b0000, 1);

    // Asynchronous reset in the middle of HOLD.
    step("rst0", 1, 4'b1100, 0);
    step("rst1", 0, 4'b0000, 0);
    check_eq("rst.hold", 32'(Dv), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst.Dv", 32'(Dv), 0);
    check_eq("rst.Do", 32'(Do), 0);
    check_eq("rst.Pend", 32'(Pend), 0);
    check_eq("rst.Err", 32'(Err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("post_rst", 0, 4'b0000, 1);

    // Random traffic with varied enable and consumer readiness.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 12; i++) step("final", 0, 4'b0000, 1);
    check_eq("final.empty", 32'(Pend), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
